// File: rtl/pdn_adder_pkg.sv
// ----------------------------------------------------------------------------
// Package : pdn_adder_pkg
// Shared mode encoding and the saturate/truncate helper for the lane adder.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pdn_adder_pkg;

  typedef enum logic [1:0] {
    ADD_M  = 2'd0,
    SUB_M  = 2'd1,
    ACC_M  = 2'd2,
    PASS_M = 2'd3
  } adder_mode_t;

  // Widest lane the helper supports; the lane sign-extends into this container.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] val;
  } sat_res_t;

  // Reduce a full-precision result to 'width' bits. ovf flags an out-of-range
  // value; the value is clamped when saturating, otherwise the low bits are kept.
  function automatic sat_res_t sat_trunc(input logic signed [MAX_W:0] r,
                                         input int                    width,
                                         input bit                    saturate);
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    sat_res_t              res;
    hi      = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo      = -hi - 65'sd1;
    res.ovf = (r > hi) || (r < lo);
    if (saturate && (r > hi)) begin
      res.val = hi[MAX_W-1:0];
    end else if (saturate && (r < lo)) begin
      res.val = lo[MAX_W-1:0];
    end else begin
      res.val = r[MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_lane.sv
// ----------------------------------------------------------------------------
// Module  : adder_lane
// One lane: mode mux, WIDTH+1 bit adder, saturate/wrap and the lane accumulator.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_lane
  import pdn_adder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  adder_mode_t      mode,
  input  logic             acc_clear,
  input  logic [WIDTH-1:0] hot,
  input  logic [WIDTH-1:0] cold,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  logic signed [WIDTH-1:0]   acc;
  logic signed [WIDTH:0]     hot_x;
  logic signed [WIDTH:0]     cold_x;
  logic signed [WIDTH:0]     base_x;
  logic signed [WIDTH:0]     sum;
  logic signed [MAX_W:0]     sum_w;
  sat_res_t                  sr;
  logic [MAX_W-WIDTH-1:0]    unused_hi;

  assign hot_x  = {hot[WIDTH-1], hot};
  assign cold_x = {cold[WIDTH-1], cold};
  assign base_x = acc_clear ? '0 : {acc[WIDTH-1], acc};

  // Full-precision per-mode result, then clamp or wrap back to WIDTH bits.
  always_comb begin
    sum = hot_x;
    case (mode)
      ADD_M:   sum = hot_x + cold_x;
      SUB_M:   sum = hot_x - cold_x;
      ACC_M:   sum = base_x + hot_x;
      PASS_M:  sum = hot_x;
      default: sum = hot_x;
    endcase
    sum_w               = {{(MAX_W - WIDTH){sum[WIDTH]}}, sum};
    sr                  = sat_trunc(sum_w, WIDTH, SATURATE);
    {unused_hi, result} = sr.val;
    ovf                 = sr.ovf;
  end

  // Accumulator advances only on accepted ACC beats, storing the reduced result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (load && (mode == ACC_M)) begin
      acc <= result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lane_adder_pipe.sv
// ----------------------------------------------------------------------------
// Module  : lane_adder_pipe
// LANES-wide signed adder with ADD/SUB/ACC/PASS modes, one registered output
// stage and valid/ready handshake on both sides.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lane_adder_pipe
  import pdn_adder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LANES    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  adder_mode_t                  mode,
  input  logic                         acc_clear,
  input  logic [LANES-1:0][WIDTH-1:0]  hot_in,
  input  logic [LANES-1:0][WIDTH-1:0]  cold_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][WIDTH-1:0]  out,
  output logic [LANES-1:0]             ovf
);

  logic                        accept;
  logic [LANES-1:0][WIDTH-1:0] lane_res;
  logic [LANES-1:0]            lane_ovf;

  // The single output slot frees up in the same cycle it is drained.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    adder_lane #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .mode      (mode),
      .acc_clear (acc_clear),
      .hot       (hot_in[i]),
      .cold      (cold_in[i]),
      .result    (lane_res[i]),
      .ovf       (lane_ovf[i])
    );
  end

  // Output stage: load on accept, drop valid once drained with nothing new behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      ovf       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out       <= lane_res;
      ovf       <= lane_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire
